operand_seq_4b: RTL and testbench
=================================

Name: operand_seq_4b

Overview:
Upstream sequencer for the 4-bit ripple adder in the lab datapath. It collects operand A and then operand B from a single shared 4-bit switch bus, one press of the load button for each. It drives A, B and carry-in to the adder and registers the adder's {cout, sum} into a held result with a valid flag. It also exports its state for LED display.

Parameters:
WIDTH, 4, operand width; must match the downstream adder (only 4 is supported).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
din  in  WIDTH  switch data, sampled on a load edge
load  in  1  pushbutton level, active-high, already synchronized to clk
clr  in  1  synchronous abort; returns to IDLE
a_out  out  WIDTH  operand A to adder
b_out  out  WIDTH  operand B to adder
cin_out  out  1  carry-in to adder
sum_in  in  WIDTH  adder sum
cout_in  in  1  adder carry-out
result  out  WIDTH+1  registered {cout, sum}
valid  out  1  result holds a completed operation
state_out  out  2  current FSM state encoding

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Edge detect:
  - load_q register; pulse = load & ~load_q.
  - load_q resets to 1, so a button held through reset produces no pulse.
- Reset values: state=IDLE, a_reg=0, b_reg=0, result=0, valid=0.
  - Outputs at reset: a_out=0, b_out=0, cin_out=0, state_out=2'b00.
- Output drive: a_out=a_reg and b_out=b_reg, continuously. cin_out=0 (add).
- FSM (encoding IDLE=00, GOT_A=01, CALC=10, DONE=11):
  - IDLE: on pulse, a_reg<=din, go to GOT_A.
  - GOT_A: on pulse, b_reg<=din, go to CALC.
  - CALC: exactly one cycle, independent of load. result<={cout_in,sum_in}, valid<=1, go to DONE.
  - DONE: result and valid hold. On pulse, a_reg<=din, valid<=0, result holds its old value, go to GOT_A (a new op starts directly).
- Latency: pulse for B seen in cycle N -> state CALC in N+1 -> valid=1 and result updated in N+2.
- Holding load high for any number of cycles counts as exactly one pulse.
- clr:
  - From any state, next state is IDLE; a_reg, b_reg and result are zeroed; valid=0.
  - clr has priority over a simultaneous pulse; the din value is discarded.
  - load_q still updates normally during clr.
- reset mid-operation: same as clr, and load_q is also set to 1.
- Arithmetic: result = A + B + cin, WIDTH+1 bits, no saturation. result[WIDTH] = adder carry-out.

Optional Feature:
OPSEQ_SUB_EN
- When defined:
  - Extra input port sub (1 bit), captured into sub_reg together with B.
  - When sub_reg=1: b_out = ~b_reg and cin_out = 1, giving result[3:0] = A-B mod 16, with result[4]=1 meaning no borrow.
  - sub_reg resets and clears to 0.
- When undefined: no sub port; b_out=b_reg and cin_out=0 always.

Test Plan:
1. reset asserted with load held high, then released, load still high for 5 cycles -> state_out=00, valid=0, result=0, no capture.
2. din=3 + load edge, then din=5 + load edge -> a_out=3, b_out=5; two cycles after the B edge, result=5'b01000 and valid=1.
3. A=4'hF, B=4'h1 -> result=5'b10000, valid=1; result holds for 20 idle cycles.
4. In DONE, load edge with din=7 -> state GOT_A, valid=0, a_out=7; a following B=2 edge gives result=5'b01001.
5. In GOT_A, clr and a load rising edge in the same cycle with din=9 -> IDLE, a_out=0, b_out=0, valid=0, b not captured.
6. (OPSEQ_SUB_EN) A=5, B=7, sub=1 -> b_out=4'h8, cin_out=1, result=5'b01110 (borrow); A=7, B=5, sub=1 -> result=5'b10010.

Source files
------------

// File: rtl/operand_seq_4b.sv
// -----------------------------------------------------------------------------
// operand_seq_4b
//
// Purpose:
//   Upstream sequencer for the lab's 4-bit ripple adder. Operand A and then
//   operand B are collected from one shared switch bus, one load-button press
//   each. A, B and carry-in are driven to the external adder, and the adder's
//   {cout, sum} is captured into a held result with a valid flag. The FSM
//   state is exported for LED display.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_din        switch data, sampled on a load rising edge
//   i_load       load pushbutton level, already synchronized to i_clk
//   i_clr        synchronous abort back to IDLE, clears operands and result
//   i_sub        (OPSEQ_SUB_EN only) subtract request, captured with B
//   o_a_out      operand A to the adder
//   o_b_out      operand B to the adder (inverted when subtracting)
//   o_cin_out    carry-in to the adder (1 when subtracting)
//   i_sum_in     adder sum
//   i_cout_in    adder carry-out
//   o_result     registered {cout, sum}
//   o_valid      o_result holds a completed operation
//   o_state_out  current FSM state (IDLE=00, GOT_A=01, CALC=10, DONE=11)
//
// Configuration:
//   OPSEQ_SUB_EN  when defined, adds the i_sub port and A-B support.
// -----------------------------------------------------------------------------
module operand_seq_4b #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_load,
    input  logic             i_clr,
`ifdef OPSEQ_SUB_EN
    input  logic             i_sub,
`endif
    output logic [WIDTH-1:0] o_a_out,
    output logic [WIDTH-1:0] o_b_out,
    output logic             o_cin_out,
    input  logic [WIDTH-1:0] i_sum_in,
    input  logic             i_cout_in,
    output logic [WIDTH:0]   o_result,
    output logic             o_valid,
    output logic [1:0]       o_state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_A = 2'b01,
        CALC  = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_loadQ;
    logic             w_pulse;
    logic             w_captureA;
    logic             w_captureB;
    logic             w_captureResult;
    logic [WIDTH-1:0] r_aReg;
    logic [WIDTH-1:0] r_bReg;
    logic [WIDTH:0]   r_result;
    logic             r_valid;

    // A press is the first cycle the button reads high. The history bit comes
    // out of reset as 1 so a button held down through reset is not a press.
    assign w_pulse = i_load & ~r_loadQ;

    // Button history keeps tracking the level even while clr is asserted, so
    // a press that overlaps clr is consumed rather than replayed afterwards.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_loadQ <= 1'b1;
        end else begin
            r_loadQ <= i_load;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the capture strobes for the datapath. clr wins over
    // a simultaneous press, so no strobe fires in a clr cycle. CALC always
    // lasts exactly one cycle, giving the adder a full cycle to settle on B.
    always_comb begin
        w_nextState     = r_state;
        w_captureA      = 1'b0;
        w_captureB      = 1'b0;
        w_captureResult = 1'b0;
        if (i_clr) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pulse) begin
                        w_captureA  = 1'b1;
                        w_nextState = GOT_A;
                    end
                end
                GOT_A: begin
                    if (w_pulse) begin
                        w_captureB  = 1'b1;
                        w_nextState = CALC;
                    end
                end
                CALC: begin
                    w_captureResult = 1'b1;
                    w_nextState     = DONE;
                end
                DONE: begin
                    if (w_pulse) begin
                        w_captureA  = 1'b1;
                        w_nextState = GOT_A;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Operand and result registers. A press in DONE starts the next operation
    // straight away: A is reloaded and valid drops, but the old result stays
    // visible on the LEDs until the new one lands.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_aReg   <= '0;
            r_bReg   <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_captureA) begin
                r_aReg  <= i_din;
                r_valid <= 1'b0;
            end
            if (w_captureB) begin
                r_bReg <= i_din;
            end
            if (w_captureResult) begin
                r_result <= {i_cout_in, i_sum_in};
                r_valid  <= 1'b1;
            end
        end
    end

`ifdef OPSEQ_SUB_EN
    logic r_subReg;

    // The add/subtract choice belongs to the operation, so it is latched with
    // B and held until the next B, a clr or a reset.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_subReg <= 1'b0;
        end else if (w_captureB) begin
            r_subReg <= i_sub;
        end
    end

    // Subtraction as A + ~B + 1 on the same adder; carry-out 1 means no borrow.
    assign o_b_out   = r_subReg ? ~r_bReg : r_bReg;
    assign o_cin_out = r_subReg;
`else
    assign o_b_out   = r_bReg;
    assign o_cin_out = 1'b0;
`endif

    assign o_a_out     = r_aReg;
    assign o_result    = r_result;
    assign o_valid     = r_valid;
    assign o_state_out = r_state;

endmodule

// File: tb/tb_operand_seq_4b.sv
// -----------------------------------------------------------------------------
// tb_operand_seq_4b
//
// Purpose:
//   Self-checking bench for operand_seq_4b. A stand-in for the ripple adder is
//   wired to the adder ports. A behavioural model tracks the expected
//   sequencer outputs from the operation rules: which operand is being
//   collected, the values held, and the arithmetic result.
//
// Configuration:
//   OPSEQ_SUB_EN  when defined, drives the subtract port and runs the
//                 subtraction scenario.
// -----------------------------------------------------------------------------
module tb_operand_seq_4b;

`ifdef OPSEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       load;
    logic       clr;
    logic       sub;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       cin_out;
    logic [3:0] sum_in;
    logic       cout_in;
    logic [4:0] result;
    logic       valid;
    logic [1:0] state_out;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model of the sequencer: phase counts operands collected
    // (0 none, 1 have A, 2 computing, 3 result ready).
    int         mPhase;
    logic [3:0] mA;
    logic [3:0] mB;
    logic       mSub;
    logic       mPrevLoad;
    logic [4:0] mResult;
    logic       mValid;

    always #5 clk = ~clk;

    // Stand-in for the downstream ripple adder.
    assign {cout_in, sum_in} = {1'b0, a_out} + {1'b0, b_out} + {4'b0000, cin_out};

    operand_seq_4b #(.WIDTH(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_din       (din),
        .i_load      (load),
        .i_clr       (clr),
`ifdef OPSEQ_SUB_EN
        .i_sub       (sub),
`endif
        .o_a_out     (a_out),
        .o_b_out     (b_out),
        .o_cin_out   (cin_out),
        .i_sum_in    (sum_in),
        .i_cout_in   (cout_in),
        .o_result    (result),
        .o_valid     (valid),
        .o_state_out (state_out)
    );

    // Arithmetic result of the collected operation, in plain integer terms.
    function automatic logic [4:0] refResult(input logic [3:0] a, input logic [3:0] b,
                                             input logic s);
        int diff;
        if (s) begin
            diff = int'(a) - int'(b);
            return {(diff >= 0), 4'((diff + 16) % 16)};
        end
        return 5'(int'(a) + int'(b));
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        logic press;
        press = load && !mPrevLoad;
        if (reset) begin
            mPhase = 0; mA = 0; mB = 0; mSub = 0; mResult = 0; mValid = 0;
            mPrevLoad = 1'b1;
        end else begin
            mPrevLoad = load;
            if (clr) begin
                mPhase = 0; mA = 0; mB = 0; mSub = 0; mResult = 0; mValid = 0;
            end else if (mPhase == 0) begin
                if (press) begin mA = din; mPhase = 1; end
            end else if (mPhase == 1) begin
                if (press) begin mB = din; mSub = SUB_EN && sub; mPhase = 2; end
            end else if (mPhase == 2) begin
                mResult = refResult(mA, mB, mSub);
                mValid  = 1'b1;
                mPhase  = 3;
            end else begin
                if (press) begin mA = din; mValid = 1'b0; mPhase = 1; end
            end
        end
    endtask

    // One clock with the given inputs; outputs are settled 1 time unit later.
    task automatic applyStimulus(input logic [3:0] d, input logic l, input logic c,
                                 input logic s);
        din  = d;
        load = l;
        clr  = c;
        sub  = s;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(4'hA, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(4'hA, 1'b1, 1'b0, 1'b0);
        nCompared++;
        if (state_out !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: got %b expected 00", state_out);
        end
        nCompared++;
        if (valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_valid: got %b expected 0", valid);
        end
        nCompared++;
        if (result !== 5'b00000) begin
            nMismatched++;
            $display("[TB] FAIL reset_result: got %b expected 00000", result);
        end
        nCompared++;
        if ({a_out, b_out, cin_out} !== 9'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_operands: got a=%h b=%h cin=%b expected 0 0 0",
                     a_out, b_out, cin_out);
        end
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_add_basic();
        applyStimulus(4'h3, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h5, 1'b1, 1'b0, 1'b0);
        nCompared++;
        if ({state_out, a_out, b_out, valid} !== {2'b10, 4'h3, 4'h5, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL add_calc: got st=%b a=%h b=%h v=%b expected 10 3 5 0",
                     state_out, a_out, b_out, valid);
        end
        applyStimulus(4'h5, 1'b1, 1'b0, 1'b0);
        nCompared++;
        if ({state_out, result, valid} !== {2'b11, 5'b01000, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL add_result: got st=%b r=%b v=%b expected 11 01000 1",
                     state_out, result, valid);
        end
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow_hold();
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h1, 1'b0, 1'b0, 1'b0);
        nCompared++;
        if ({result, valid} !== {5'b10000, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL overflow_result: got r=%b v=%b expected 10000 1", result, valid);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
            nCompared++;
            if ({state_out, result, valid} !== {2'b11, 5'b10000, 1'b1}) begin
                nMismatched++;
                $display("[TB] FAIL overflow_hold[%0d]: got st=%b r=%b v=%b expected 11 10000 1",
                         i, state_out, result, valid);
            end
        end
    endtask

    task automatic test_done_restart();
        applyStimulus(4'h7, 1'b1, 1'b0, 1'b0);
        nCompared++;
        if ({state_out, valid, a_out, result} !== {2'b01, 1'b0, 4'h7, 5'b10000}) begin
            nMismatched++;
            $display("[TB] FAIL restart_a: got st=%b v=%b a=%h r=%b expected 01 0 7 10000",
                     state_out, valid, a_out, result);
        end
        applyStimulus(4'h7, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h2, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h2, 1'b0, 1'b0, 1'b0);
        nCompared++;
        if ({result, valid} !== {5'b01001, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL restart_result: got r=%b v=%b expected 01001 1", result, valid);
        end
    endtask

    task automatic test_clr_priority();
        applyStimulus(4'h6, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h6, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h9, 1'b1, 1'b1, 1'b0);
        nCompared++;
        if ({state_out, a_out, b_out, valid, result} !== {2'b00, 4'h0, 4'h0, 1'b0, 5'b00000}) begin
            nMismatched++;
            $display("[TB] FAIL clr_priority: got st=%b a=%h b=%h v=%b r=%b expected 00 0 0 0 00000",
                     state_out, a_out, b_out, valid, result);
        end
        applyStimulus(4'h9, 1'b1, 1'b0, 1'b0);
        nCompared++;
        if ({state_out, a_out} !== {2'b00, 4'h0}) begin
            nMismatched++;
            $display("[TB] FAIL clr_held_load: got st=%b a=%h expected 00 0", state_out, a_out);
        end
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef OPSEQ_SUB_EN
    task automatic test_sub();
        applyStimulus(4'h5, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h5, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h7, 1'b1, 1'b0, 1'b1);
        nCompared++;
        if ({b_out, cin_out} !== {4'h8, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL sub_drive: got b=%h cin=%b expected 8 1", b_out, cin_out);
        end
        applyStimulus(4'h7, 1'b0, 1'b0, 1'b0);
        nCompared++;
        if ({result, valid} !== {5'b01110, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL sub_borrow: got r=%b v=%b expected 01110 1", result, valid);
        end
        applyStimulus(4'h7, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h7, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h5, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'h5, 1'b0, 1'b0, 1'b0);
        nCompared++;
        if ({result, valid} !== {5'b10010, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL sub_noborrow: got r=%b v=%b expected 10010 1", result, valid);
        end
    endtask
`endif

    // Randomized traffic: held and toggling button, occasional clr and reset.
    task automatic test_random();
        logic       nextLoad;
        logic [3:0] expB;
        logic [17:0] expVec;
        logic [17:0] gotVec;
        nextLoad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) nextLoad = ~nextLoad;
            reset = ($urandom_range(0, 79) == 0);
            applyStimulus(4'($urandom_range(0, 15)), nextLoad,
                          ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
            expB   = mSub ? ~mB : mB;
            expVec = {2'(mPhase), mA, expB, mSub, mResult, mValid};
            gotVec = {state_out, a_out, b_out, cin_out, result, valid};
            nCompared++;
            if (gotVec !== expVec) begin
                nMismatched++;
                $display("[TB] FAIL random[%0d]: got st=%b a=%h b=%h cin=%b r=%b v=%b expected st=%b a=%h b=%h cin=%b r=%b v=%b",
                         i, state_out, a_out, b_out, cin_out, result, valid,
                         2'(mPhase), mA, expB, mSub, mResult, mValid);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        din   = 4'h0;
        load  = 1'b0;
        clr   = 1'b0;
        sub   = 1'b0;
        mPhase = 0; mA = 0; mB = 0; mSub = 0; mResult = 0; mValid = 0; mPrevLoad = 1'b1;
        test_reset();
        test_add_basic();
        test_overflow_hold();
        test_done_restart();
        test_clr_priority();
`ifdef OPSEQ_SUB_EN
        test_sub();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
